// File: rtl/banco_registradores.sv
// Parametrised register bank with in-place load/inc/dec/shift/rotate/clear,
// two combinational read ports and registered carry/zero flags.
module banco_registradores #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             n_write,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    addr_w,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic [AW-1:0]    addr_a,
    input  logic [AW-1:0]    addr_b,
    output logic [WIDTH-1:0] s_a,
    output logic [WIDTH-1:0] s_b,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_INC  = 3'b001,
        OP_DEC  = 3'b010,
        OP_SHL  = 3'b011,
        OP_SHR  = 3'b100,
        OP_CLR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_ROR  = 3'b111
    } op_t;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] res;
    logic             c_next;
    logic             hit;
    op_t              op_sel;

    assign op_sel = op_t'(op);

    // Address decode by comparison, so addresses >= DEPTH never index the array
    // and simply read as zero / write nothing.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        s_a = '0;
        s_b = '0;
        cur = '0;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_a == AW'(i)) s_a = regs[i];
            if (addr_b == AW'(i)) s_b = regs[i];
            if (addr_w == AW'(i)) begin
                cur = regs[i];
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        res    = cur;
        c_next = carry;
        case (op_sel)
            OP_LOAD: begin
                res    = d;
                c_next = 1'b0;
            end
            OP_INC:  {c_next, res} = {1'b0, cur} + (WIDTH+1)'(1);
            OP_DEC:  {c_next, res} = {1'b0, cur} - (WIDTH+1)'(1);
            OP_SHL:  {c_next, res} = {cur, ser_in};
            OP_SHR:  {res, c_next} = {ser_in, cur};
            OP_CLR: begin
                res    = '0;
                c_next = 1'b0;
            end
            OP_ROL:  {c_next, res} = {cur, cur[WIDTH-1]};
            OP_ROR:  {res, c_next} = {cur[0], cur};
            default: begin
                res    = cur;
                c_next = carry;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the bank is a handful of flops whose zero state is architecturally visible, so each entry is reset.
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
        end else if (!n_write && hit) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_w == AW'(i)) regs[i] <= res;
            end
            carry <= c_next;
            zero  <= (res == '0);
        end
    end

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench: an 8x4 bank and a 12x3 bank checked every cycle
// against an arithmetic reference model, plus directed literal checks.
module tb_banco_registradores;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       nw0, si0, c0, z0;
    logic [2:0] op0;
    logic [1:0] aw0, ra0, rb0;
    logic [7:0] d0, sa0, sb0;

    logic        nw1, si1, c1, z1;
    logic [2:0]  op1;
    logic [1:0]  aw1, ra1, rb1;
    logic [11:0] d1, sa1, sb1;

    banco_registradores dut8 (
        .clk(clk), .rst(rst), .n_write(nw0), .op(op0), .addr_w(aw0), .d(d0),
        .ser_in(si0), .addr_a(ra0), .addr_b(rb0), .s_a(sa0), .s_b(sb0),
        .carry(c0), .zero(z0)
    );

    banco_registradores #(.WIDTH(12), .DEPTH(3), .AW(2)) dut12 (
        .clk(clk), .rst(rst), .n_write(nw1), .op(op1), .addr_w(aw1), .d(d1),
        .ser_in(si1), .addr_a(ra1), .addr_b(rb1), .s_a(sa1), .s_b(sb1),
        .carry(c1), .zero(z1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Reference model: register values as plain integers.
    int m [2][4];
    int mc[2];
    int mz[2];

    function automatic int width_of(input int k);
        return (k == 1) ? 12 : 8;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 1) ? 3 : 4;
    endfunction

    function automatic int rd(input int k, input int a);
        return (a < depth_of(k)) ? m[k][a] : 0;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 4; a++) m[k][a] = 0;
            mc[k] = 0;
            mz[k] = 1;
        end
    endtask

    task automatic model_step(input int k, input int op, input int a, input int dv, input int si);
        int r, n, c, modv, top;
        if (a >= depth_of(k)) return;
        modv = 1 << width_of(k);
        top  = 1 << (width_of(k) - 1);
        r = m[k][a];
        case (op)
            0: begin n = dv % modv;              c = 0;                   end
            1: begin n = (r + 1) % modv;         c = (r == modv - 1);     end
            2: begin n = (r + modv - 1) % modv;  c = (r == 0);            end
            3: begin n = (r * 2 + si) % modv;    c = (r >= top);          end
            4: begin n = si * top + r / 2;       c = r % 2;               end
            5: begin n = 0;                      c = 0;                   end
            6: begin n = (r * 2) % modv + ((r >= top) ? 1 : 0); c = (r >= top); end
            default: begin n = (r % 2) * top + r / 2; c = r % 2;          end
        endcase
        m[k][a] = n;
        mc[k] = c;
        mz[k] = (n == 0) ? 1 : 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic do_op(input int k, input int op, input int a, input int dv, input int si);
        if (k == 0) begin
            nw0 = 1'b0; op0 = 3'(op); aw0 = 2'(a); d0 = 8'(dv); si0 = 1'(si);
            nw1 = 1'b1;
        end else begin
            nw1 = 1'b0; op1 = 3'(op); aw1 = 2'(a); d1 = 12'(dv); si1 = 1'(si);
            nw0 = 1'b1;
        end
        @(posedge clk);
        model_step(k, op, a, dv, si);
        #1;
        nw0 = 1'b1;
        nw1 = 1'b1;
    endtask

    // Disabled cycle with junk on the op/address/data inputs.
    task automatic idle_cycle();
        nw0 = 1'b1; nw1 = 1'b1;
        op0 = 3'($urandom_range(0, 7)); aw0 = 2'($urandom_range(0, 3)); d0 = 8'($urandom);
        op1 = 3'($urandom_range(0, 7)); aw1 = 2'($urandom_range(0, 3)); d1 = 12'($urandom);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("cmp8_s_a",   int'(sa0), rd(0, int'(ra0)));
            check("cmp8_s_b",   int'(sb0), rd(0, int'(rb0)));
            check("cmp8_carry", int'(c0),  mc[0]);
            check("cmp8_zero",  int'(z0),  mz[0]);
            check("cmp12_s_a",   int'(sa1), rd(1, int'(ra1)));
            check("cmp12_s_b",   int'(sb1), rd(1, int'(rb1)));
            check("cmp12_carry", int'(c1),  mc[1]);
            check("cmp12_zero",  int'(z1),  mz[1]);
        end
    end

    initial begin
        rst = 1'b1;
        nw0 = 1'b1; op0 = '0; aw0 = '0; d0 = '0; si0 = 1'b0; ra0 = '0; rb0 = '0;
        nw1 = 1'b1; op1 = '0; aw1 = '0; d1 = '0; si1 = 1'b0; ra1 = '0; rb1 = '0;
        @(posedge clk);
        do_reset();
        checking = 1'b1;

        // Reset state on every address of both ports.
        for (int a = 0; a < 4; a++) begin
            ra0 = 2'(a); rb0 = 2'(3 - a);
            #1;
            check("rst_s_a", int'(sa0), 0);
            check("rst_s_b", int'(sb0), 0);
        end
        check("rst_carry", int'(c0), 0);
        check("rst_zero",  int'(z0), 1);

        // Reset in mid-sequence.
        ra0 = 2'd0;
        do_op(0, 0, 0, 'h5A, 0);
        check("load_5a", int'(sa0), 'h5A);
        check("load_5a_zero", int'(z0), 0);
        do_reset();
        check("rst_mid_reg", int'(sa0), 0);
        check("rst_mid_zero", int'(z0), 1);

        // INC wrap and DEC borrow.
        ra0 = 2'd1;
        do_op(0, 0, 1, 'hFF, 0);
        do_op(0, 1, 1, 0, 0);
        check("inc_wrap", int'(sa0), 'h00);
        check("inc_carry", int'(c0), 1);
        check("inc_zero", int'(z0), 1);
        check("model_inc_wrap", rd(0, 1), 'h00);
        do_op(0, 2, 1, 0, 0);
        check("dec_borrow", int'(sa0), 'hFF);
        check("dec_carry", int'(c0), 1);
        check("dec_zero", int'(z0), 0);

        // Shifts and rotates.
        ra0 = 2'd2;
        do_op(0, 0, 2, 'h81, 0);
        do_op(0, 3, 2, 0, 0);
        check("shl", int'(sa0), 'h02);
        check("shl_carry", int'(c0), 1);
        do_op(0, 4, 2, 0, 1);
        check("shr", int'(sa0), 'h81);
        check("shr_carry", int'(c0), 0);
        do_op(0, 7, 2, 0, 0);
        check("ror", int'(sa0), 'hC0);
        check("ror_carry", int'(c0), 1);
        check("model_ror", rd(0, 2), 'hC0);
        do_op(0, 6, 2, 0, 0);
        check("rol", int'(sa0), 'h81);
        check("rol_carry", int'(c0), 1);

        // No write-through, then a disabled CLR.
        ra0 = 2'd0;
        nw0 = 1'b0; op0 = 3'd0; aw0 = 2'd0; d0 = 8'h3C; si0 = 1'b0;
        #1;
        check("no_write_through", int'(sa0), 'h00);
        @(posedge clk);
        model_step(0, 0, 0, 'h3C, 0);
        #1;
        check("load_3c_next", int'(sa0), 'h3C);
        nw0 = 1'b1; op0 = 3'd5; aw0 = 2'd0;
        @(posedge clk);
        #1;
        check("disabled_clr_reg", int'(sa0), 'h3C);
        check("disabled_clr_carry", int'(c0), 0);
        check("disabled_clr_zero", int'(z0), 0);

        // 12-bit bank: out-of-range write and 12-bit INC wrap.
        do_op(1, 0, 0, 'h005, 0);
        do_op(1, 0, 3, 'hABC, 0);
        ra1 = 2'd3; rb1 = 2'd0;
        #1;
        check("oor_read", int'(sa1), 0);
        check("oor_reg0_hold", int'(sb1), 'h005);
        check("oor_carry_hold", int'(c1), 0);
        check("oor_zero_hold", int'(z1), 0);
        ra1 = 2'd2;
        do_op(1, 0, 2, 'hFFF, 0);
        do_op(1, 1, 2, 0, 0);
        check("inc12_wrap", int'(sa1), 'h000);
        check("inc12_carry", int'(c1), 1);
        check("inc12_zero", int'(z1), 1);

        // Random op/address stream checked every cycle by the compare process.
        for (int i = 0; i < 1000; i++) begin
            ra0 = 2'($urandom_range(0, 3)); rb0 = 2'($urandom_range(0, 3));
            ra1 = 2'($urandom_range(0, 3)); rb1 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                int k;
                k = int'($urandom_range(0, 1));
                do_op(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      (k == 1) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
